// File: rtl/link_pkg.sv
// Shared types and helpers for the FPGA1->FPGA2 link transmit arbiter.
package link_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitDone = 3'd2,
    StComplete = 3'd3,
    StFlush    = 3'd4
  } state_e;

  localparam int unsigned DefaultDataW = 32;

  // Ceiling log2; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first pending index after last_i, wrapping.
module rr_picker
  import link_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IdW-1:0]     last_i,
  output logic               valid_o,
  output logic [IdW-1:0]     idx_o
);

  localparam int unsigned SumW = IdW + 1;

  logic [SumW-1:0] sum;
  logic [IdW-1:0]  cand;

  // Scan offsets 1..NUM_REQ from the last grant; the earliest pending candidate wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_i} + SumW'(off);
      if (sum >= SumW'(NUM_REQ)) sum = sum - SumW'(NUM_REQ);
      cand = sum[IdW-1:0];
      if (!valid_o && pending_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// Round-robin sharing of the single link sender among NUM_REQ producers, with
// per-transfer timeout, sender flush and bounded retry.
module link_tx_arbiter
  import link_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY = 2,
  localparam int unsigned ID_W = clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_start_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic [NUM_REQ-1:0]        req_pending_o,
  output logic                      snd_start_o,
  output logic [DATA_W-1:0]         snd_data_o,
  input  logic                      snd_done_i,
  output logic                      snd_flush_o,
  output logic                      busy_o,
  output logic [ID_W-1:0]           grant_id_o
);

  localparam int unsigned TimerW = clog2(TIMEOUT);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? clog2(MAX_RETRY + 1) : 1;
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT - 1);
  localparam logic [RetryW-1:0] MaxRetryL   = RetryW'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0]   hold_q [NUM_REQ];
  logic [DATA_W-1:0]   hold_d [NUM_REQ];

  logic [NUM_REQ-1:0]  clr;
  logic [NUM_REQ-1:0]  accept;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;
  logic                retry_left;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .pending_i (pending_q),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  assign grant_oh   = NUM_REQ'(1) << grant_q;
  assign retry_left = (retry_q < MaxRetryL);

  // Next-state logic for the transfer sequencer; clr marks the requester being retired.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    timer_d = timer_q;
    retry_d = retry_q;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          data_d  = hold_q[pick_idx];
          retry_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        timer_d = timer_q + 1'b1;
        // An ack in the last allowed cycle still counts as success.
        if (snd_done_i) begin
          state_d = StComplete;
        end else if (timer_q == TimeoutLast) begin
          state_d = StFlush;
        end
      end
      StComplete: begin
        clr[grant_q] = 1'b1;
        state_d      = StIdle;
      end
      StFlush: begin
        if (retry_left) begin
          retry_d = retry_q + 1'b1;
          state_d = StIssue;
        end else begin
          clr[grant_q] = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture new words; a start in the same cycle as the retire of that slot wins.
  always_comb begin
    accept    = req_start_i & (~pending_q | clr);
    pending_d = (pending_q & ~clr) | accept;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hold_d[i] = accept[i] ? req_data_i[i*DATA_W +: DATA_W] : hold_q[i];
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      data_q    <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  // Outputs are registers or decodes of registered state only.
  always_comb begin
    snd_start_o   = (state_q == StIssue);
    snd_flush_o   = (state_q == StFlush);
    busy_o        = (state_q != StIdle);
    req_done_o    = (state_q == StComplete) ? grant_oh : '0;
    req_err_o     = (state_q == StFlush && !retry_left) ? grant_oh : '0;
    req_pending_o = pending_q;
    snd_data_o    = data_q;
    grant_id_o    = grant_q;
  end

endmodule
